// File: rtl/downscale_sequencer.sv
// downscale_sequencer: host BRAM access port plus a nearest-neighbour downscale engine (ports: clk, rst active-low async, cfg_* host access, start_req, bram_* BRAM port, busy/done/dbg_*/cfg_err status)
module downscale_sequencer #(
  parameter int SRC_W = 32,
  parameter int SRC_H = 32,
  parameter int DST_W = 16,
  parameter int DST_H = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic        cfg_re,
  input  logic [15:0] cfg_addr,
  input  logic [7:0]  cfg_data,
  input  logic        start_req,
  output logic        bram_we,
  output logic [15:0] bram_addr,
  output logic [7:0]  bram_wr_data,
  input  logic [7:0]  bram_rd_data,
  output logic        busy,
  output logic        done,
  output logic [7:0]  dbg_data,
  output logic        dbg_valid,
  output logic        cfg_err
);
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_t;
  localparam logic [15:0] SX_STEP  = 16'(SRC_W / DST_W);
  localparam logic [15:0] RB_STEP  = 16'((SRC_H / DST_H) * SRC_W);
  localparam logic [15:0] DST_BASE = 16'(SRC_W * SRC_H);
  localparam logic [15:0] DX_LAST  = 16'(DST_W - 1);
  localparam logic [15:0] DY_LAST  = 16'(DST_H - 1);
  state_t state, state_nx;
  logic [15:0] dx, dy, sx, row_base, dst_off;
  logic [7:0] pix;
  logic rd_pend, host, host_ok, launch, last;
  always_comb begin
    host     = (state == IDLE) || (state == DONE);
    launch   = host & start_req;
    host_ok  = host & ~start_req;
    last     = (dx == DX_LAST) && (dy == DY_LAST);
    busy     = (state == RD) || (state == WAIT) || (state == WR);
    done     = state == DONE;
    state_nx = launch ? RD :
               state == RD ? WAIT :
               state == WAIT ? WR :
               state == WR ? (last ? DONE : RD) :
               (state == DONE && cfg_we) ? IDLE : state;
    // BRAM port is forced quiet while reset is asserted, even for host pass-through
    bram_we      = rst & ((host_ok & cfg_we) | (state == WR));
    bram_addr    = !rst ? 16'd0 :
                   state == RD ? row_base + sx :
                   state == WR ? DST_BASE + dst_off :
                   (host_ok & (cfg_we | cfg_re)) ? cfg_addr : 16'd0;
    bram_wr_data = !rst ? 8'd0 :
                   state == WR ? pix :
                   (host_ok & cfg_we) ? cfg_data : 8'd0;
    dbg_valid    = rd_pend;
    dbg_data     = rd_pend ? bram_rd_data : 8'd0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dx       <= '0;
      dy       <= '0;
      sx       <= '0;
      row_base <= '0;
      dst_off  <= '0;
      pix      <= '0;
      rd_pend  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state   <= state_nx;
      rd_pend <= host_ok & cfg_re & ~cfg_we;
      if (launch) begin
        dx       <= '0;
        dy       <= '0;
        sx       <= '0;
        row_base <= '0;
        dst_off  <= '0;
        cfg_err  <= cfg_we | cfg_re;
      end else if (busy & (cfg_we | cfg_re)) begin
        cfg_err <= 1'b1;
      end
      if (state == WAIT) pix <= bram_rd_data;
      if (state == WR) begin
        dst_off <= dst_off + 16'd1;
        if (dx == DX_LAST) begin
          dx       <= '0;
          sx       <= '0;
          dy       <= dy + 16'd1;
          row_base <= row_base + RB_STEP;
        end else begin
          dx <= dx + 16'd1;
          sx <= sx + SX_STEP;
        end
      end
    end
  end
endmodule

// File: tb/tb_downscale_sequencer.sv
// tb_downscale_sequencer: directed self-checking bench with a synchronous BRAM model
module tb_downscale_sequencer;
  logic clk = 0, rst = 0, cfg_we = 0, cfg_re = 0, start_req = 0;
  logic [15:0] cfg_addr = 0;
  logic [7:0] cfg_data = 0;
  logic bram_we, busy, done, dbg_valid, cfg_err;
  logic [15:0] bram_addr;
  logic [7:0] bram_wr_data, bram_rd_data, dbg_data;
  logic [7:0] mem [0:65535];
  int checks = 0, failures = 0, wr_cnt = 0, snap, n;

  downscale_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start_req(start_req), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wr_data(bram_wr_data), .bram_rd_data(bram_rd_data), .busy(busy), .done(done),
    .dbg_data(dbg_data), .dbg_valid(dbg_valid), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_wr_data;
    bram_rd_data <= mem[bram_addr];
    if (bram_we && bram_addr >= 16'd1024 && bram_addr < 16'd1280) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [15:0] a, input logic [7:0] d);
    cfg_we = 1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 0;
  endtask

  task automatic fill_dst(input logic [7:0] d);
    for (int i = 0; i < 256; i++) host_wr(16'(1024 + i), d);
  endtask

  task automatic wait_done(input bit inj, output int cnt);
    cnt = 0;
    while (!done && cnt < 2000) begin
      tick();
      cnt++;
      if (inj && cnt == 10) begin
        cfg_we = 1; cfg_addr = 16'd3000; cfg_data = 8'hAA;
        #1 chk("busy_cfg_we_no_bram_write", {31'd0, bram_we}, 32'd0);
      end
      if (inj && cnt == 11) begin
        cfg_we = 0;
        chk("busy_cfg_we_sets_err", {31'd0, cfg_err}, 32'd1);
      end
    end
  endtask

  task automatic check_dst(input string tag);
    int bad;
    bad = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        if (mem[1024 + y * 16 + x] !== 8'((64 * y + 2 * x) & 8'hFF)) bad++;
    chk(tag, bad, 0);
  endtask

  initial begin
    cfg_we = 1; cfg_addr = 16'h1234; cfg_data = 8'h5A;
    #2;
    chk("rst_bram_we", {31'd0, bram_we}, 0);
    chk("rst_bram_addr", {16'd0, bram_addr}, 0);
    chk("rst_bram_wr_data", {24'd0, bram_wr_data}, 0);
    chk("rst_status", {27'd0, busy, done, dbg_valid, cfg_err, |dbg_data}, 0);
    cfg_we = 0;
    tick(); tick();
    rst = 1;
    tick();
    cfg_we = 1; cfg_addr = 16'd7; cfg_data = 8'h07;
    #1;
    chk("pass_we", {31'd0, bram_we}, 1);
    chk("pass_addr", {16'd0, bram_addr}, 7);
    chk("pass_data", {24'd0, bram_wr_data}, 8'h07);
    cfg_we = 0;
    for (int i = 0; i < 1024; i++) host_wr(16'(i), 8'(i));
    host_wr(16'd2000, 8'd0);
    host_wr(16'd3000, 8'd0);
    fill_dst(8'hFF);
    // plain run
    snap = wr_cnt;
    start_req = 1;
    tick();
    start_req = 0;
    chk("start_busy", {30'd0, busy, done}, 2'b10);
    wait_done(0, n);
    chk("run1_latency", n, 768);
    chk("run1_writes", wr_cnt - snap, 256);
    chk("run1_err", {31'd0, cfg_err}, 0);
    check_dst("run1_dst");
    // host read while DONE
    cfg_re = 1; cfg_addr = 16'd1041;
    #1 chk("rd_addr", {16'd0, bram_addr}, 1041);
    chk("rd_no_valid_yet", {31'd0, dbg_valid}, 0);
    tick();
    cfg_re = 0;
    chk("rd_valid", {31'd0, dbg_valid}, 1);
    chk("rd_data", {24'd0, dbg_data}, 8'h42);
    chk("rd_done_stays", {31'd0, done}, 1);
    tick();
    chk("rd_valid_strobe", {31'd0, dbg_valid}, 0);
    // start and cfg_we together
    start_req = 1; cfg_we = 1; cfg_addr = 16'd2000; cfg_data = 8'h55;
    #1 chk("start_drops_we", {31'd0, bram_we}, 0);
    tick();
    start_req = 0; cfg_we = 0;
    chk("start_we_err", {31'd0, cfg_err}, 1);
    chk("start_we_busy", {31'd0, busy}, 1);
    wait_done(0, n);
    chk("run2_latency", n, 768);
    chk("run2_dropped_wr", {24'd0, mem[2000]}, 0);
    // write while busy
    fill_dst(8'hFF);
    snap = wr_cnt;
    start_req = 1;
    tick();
    start_req = 0;
    chk("run3_err_cleared", {31'd0, cfg_err}, 0);
    wait_done(1, n);
    chk("run3_latency", n, 768);
    chk("run3_writes", wr_cnt - snap, 256);
    chk("run3_ignored_wr", {24'd0, mem[3000]}, 0);
    chk("run3_err_sticky", {31'd0, cfg_err}, 1);
    check_dst("run3_dst");
    // start held across a whole run
    start_req = 1;
    tick();
    chk("run4_err_cleared", {31'd0, cfg_err}, 0);
    wait_done(0, n);
    chk("run4_latency", n, 768);
    tick();
    chk("run4_restart", {30'd0, busy, done}, 2'b10);
    start_req = 0;
    wait_done(0, n);
    chk("run5_latency", n, 768);
    // DONE exits on host write
    host_wr(16'd5000, 8'h77);
    chk("done_exit", {31'd0, done}, 0);
    chk("done_exit_wr", {24'd0, mem[5000]}, 8'h77);
    // reset mid-run
    fill_dst(8'hFF);
    start_req = 1;
    tick();
    start_req = 0;
    repeat (300) tick();
    rst = 0;
    #1;
    chk("midrst_outputs", {10'd0, bram_we, bram_addr, busy, done, dbg_valid, cfg_err, |dbg_data, |bram_wr_data}, 0);
    snap = wr_cnt;
    repeat (5) tick();
    chk("midrst_no_writes", wr_cnt - snap, 0);
    rst = 1;
    tick();
    chk("midrst_idle", {30'd0, busy, done}, 0);
    start_req = 1;
    tick();
    start_req = 0;
    wait_done(0, n);
    chk("run6_latency", n, 768);
    check_dst("run6_dst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
